// File: rtl/echo_p2m_pkg.sv
// echo_p2m_pkg
//   Shared definitions for the EchoIndication pipe-to-method deserializer:
//   method ids, the expected message length, payload field positions and
//   the 144-bit message layout {id, len, payload[95:0], tag}.
package echo_p2m_pkg;

    localparam int MSG_W = 144;

    // Method ids carried in the message id field.
    localparam logic [15:0] HEARD   = 16'd0;
    localparam logic [15:0] HEARD2  = 16'd1;
    localparam logic [15:0] HEARD3  = 16'd2;

    // Every well-formed EchoIndication message reports length 5.
    localparam logic [15:0] MSG_LEN = 16'd5;

    // Field offsets inside the full 144-bit message.
    localparam int ID_LSB      = 128;
    localparam int LEN_LSB     = 112;
    localparam int PAYLOAD_LSB = 16;
    localparam int TAG_LSB     = 0;

    // Argument MSBs inside the 96-bit payload (payload bit 95 = message bit 111).
    localparam int PL_V_MSB = 95;   // heard.v   32 bits
    localparam int PL_A_MSB = 95;   // heard2/3.a 16 bits
    localparam int PL_B_MSB = 79;   // heard2/3.b 16 bits
    localparam int PL_C_MSB = 63;   // heard3.c  32 bits
    localparam int PL_D_MSB = 31;   // heard3.d  32 bits

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] len;
        logic [95:0] payload;
        logic [15:0] tag;
    } echo_msg_t;

    // A message is deliverable only with the fixed length and a known id.
    function automatic logic msg_is_good(input echo_msg_t m);
        return (m.len == MSG_LEN) && (m.id <= HEARD3);
    endfunction

endpackage

// File: rtl/p2m_fifo.sv
// p2m_fifo
//   DEPTH-entry circular buffer of EchoIndication messages.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset (pointers/count only)
//     wr_en        write request; ignored while full
//     wr_data      message to store
//     rd_en        pop request; ignored while empty
//     rd_data      head entry (valid while !empty)
//     full, empty  occupancy flags derived from the registered count
module p2m_fifo
    import echo_p2m_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  echo_msg_t wr_data,
    input  logic      rd_en,
    output echo_msg_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    echo_msg_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: entries are only observed through the valid count.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/p2m_echo_indication.sv
// p2m_echo_indication
//   Pipe-to-method deserializer for the EchoIndication interface. Buffers
//   144-bit messages and replays each as one heard/heard2/heard3 call.
//   Optional feature macro: P2M_ERRCNT_EN adds the err_count port, a
//   saturating count of dropped (bad) messages.
//   Ports:
//     CLK, nRST               clock, asynchronous active-low reset
//     pipe_enq__ENA/_v/__RDY  upstream message pipe (RDY = buffer not full)
//     heard__ENA, heard_v, heard__RDY
//     heard2__ENA, heard2_a, heard2_b, heard2__RDY
//     heard3__ENA, heard3_a.._d, heard3__RDY
//                             EchoIndication client method port
//     err_count               dropped-message count (P2M_ERRCNT_EN only)
module p2m_echo_indication
    import echo_p2m_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         pipe_enq__ENA,
    input  logic [143:0] pipe_enq_v,
    output logic         pipe_enq__RDY,
    output logic         heard__ENA,
    output logic [31:0]  heard_v,
    input  logic         heard__RDY,
    output logic         heard2__ENA,
    output logic [15:0]  heard2_a,
    output logic [15:0]  heard2_b,
    input  logic         heard2__RDY,
    output logic         heard3__ENA,
    output logic [15:0]  heard3_a,
    output logic [15:0]  heard3_b,
    output logic [31:0]  heard3_c,
    output logic [31:0]  heard3_d,
    input  logic         heard3__RDY
`ifdef P2M_ERRCNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    echo_msg_t head;
    echo_msg_t enq_msg;
    logic      fifo_full;
    logic      fifo_empty;
    logic      head_vld;
    logic      head_good;
    logic      sel_h1;
    logic      sel_h2;
    logic      sel_h3;
    logic      drop_bad;
    logic      deq;
    logic      unused_tag;

    assign enq_msg = pipe_enq_v;

    p2m_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .wr_en   (pipe_enq__ENA),
        .wr_data (enq_msg),
        .rd_en   (deq),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // RDY comes from registered occupancy only, so a full buffer refuses
    // a write even when the head is leaving in the same cycle.
    assign pipe_enq__RDY = !fifo_full;

    assign head_vld  = !fifo_empty;
    assign head_good = msg_is_good(head);
    assign sel_h1    = head_vld && head_good && (head.id == HEARD);
    assign sel_h2    = head_vld && head_good && (head.id == HEARD2);
    assign sel_h3    = head_vld && head_good && (head.id == HEARD3);
    assign drop_bad  = head_vld && !head_good;

    assign heard__ENA  = sel_h1 && heard__RDY;
    assign heard2__ENA = sel_h2 && heard2__RDY;
    assign heard3__ENA = sel_h3 && heard3__RDY;

    // Data follows the selected head even while stalled; other methods read 0.
    assign heard_v  = sel_h1 ? head.payload[PL_V_MSB -: 32] : '0;
    assign heard2_a = sel_h2 ? head.payload[PL_A_MSB -: 16] : '0;
    assign heard2_b = sel_h2 ? head.payload[PL_B_MSB -: 16] : '0;
    assign heard3_a = sel_h3 ? head.payload[PL_A_MSB -: 16] : '0;
    assign heard3_b = sel_h3 ? head.payload[PL_B_MSB -: 16] : '0;
    assign heard3_c = sel_h3 ? head.payload[PL_C_MSB -: 32] : '0;
    assign heard3_d = sel_h3 ? head.payload[PL_D_MSB -: 32] : '0;

    // Bad messages leave in one cycle; good ones leave only when accepted.
    assign deq = drop_bad || heard__ENA || heard2__ENA || heard3__ENA;

    // The arg-word tag is carried for the transport but not needed here.
    assign unused_tag = ^head.tag;

`ifdef P2M_ERRCNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_count <= '0;
        end else if (drop_bad && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
